// File: rtl/psum_accum_engine_if.sv
// psum_accum_engine_if: psum memory controller port.
// The engine (master) issues reads and writes, and the memory controller (slave) returns read data.
interface psum_accum_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] memctrl_radd;
    logic                  memctrl_rden;
    logic [DATA_WIDTH-1:0] memctrl_odat;
    logic                  memctrl_ovld;
    logic [ADDR_WIDTH-1:0] memctrl_wadd;
    logic                  memctrl_wren;
    logic [DATA_WIDTH-1:0] memctrl_idat;

    modport master (
        output memctrl_radd, memctrl_rden, memctrl_wadd, memctrl_wren, memctrl_idat,
        input  memctrl_odat, memctrl_ovld
    );
    modport slave (
        input  memctrl_radd, memctrl_rden, memctrl_wadd, memctrl_wren, memctrl_idat,
        output memctrl_odat, memctrl_ovld
    );
endinterface

// File: rtl/psum_accum_engine.sv
// psum_accum_engine: multi-pass read-modify-write psum accumulator with RAW forwarding over the read pipe.
// Optional PSUM_ACC_SAT_EN: saturating lane adds, and each saturation event also sets o_err.
module psum_accum_engine #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32,
    parameter int MEM_DELAY  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    input  logic [NUM_KERNEL*BIT_WIDTH-1:0] i_psum_dat,
    input  logic                            i_psum_vld,
    psum_accum_engine_if.master             mem,
    input  logic [REG_WIDTH-1:0]            i_conf_interval,
    input  logic [REG_WIDTH-1:0]            i_conf_npass,
    input  logic [REG_WIDTH-1:0]            i_conf_ngroup,
    input  logic [ADDR_WIDTH-1:0]           i_conf_gstep,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_err
);
    localparam int DW = NUM_KERNEL * BIT_WIDTH;
    localparam int D  = MEM_DELAY;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [REG_WIDTH-1:0]  interval, npass, ngroup, pt_cnt, pass_cnt, grp_cnt;
    logic [ADDR_WIDTH-1:0] gstep, base, addr;
    logic                  start, accept, pt_wrap, pass_wrap, last;

    logic [D-1:0]          p_vld, p_first;
    logic [DW-1:0]         p_dat  [D];
    logic [ADDR_WIDTH-1:0] p_addr [D];

    // h[j] is the write issued j+1 cycles ago; with the current write it spans the hazard window
    logic [D-1:0]          h_vld;
    logic [DW-1:0]         h_dat  [D];
    logic [ADDR_WIDTH-1:0] h_addr [D];

    logic                  rd_exp, fwd_hit;
    logic [DW-1:0]         fwd_dat, rdata, sum, wdat;
    logic [NUM_KERNEL-1:0] lane_sat;

    assign start     = i_start && (state == IDLE || state == DONE);
    assign accept    = state == RUN && i_psum_vld;
    assign pt_wrap   = pt_cnt == interval - REG_WIDTH'(1);
    assign pass_wrap = pt_wrap && pass_cnt == npass - REG_WIDTH'(1);
    assign last      = pass_wrap && grp_cnt == ngroup - REG_WIDTH'(1);
    assign addr      = base + ADDR_WIDTH'(pt_cnt);
    assign o_busy    = state == RUN || state == DRAIN;
    assign rd_exp    = p_vld[D-1] && !p_first[D-1];

    assign mem.memctrl_rden = accept && pass_cnt != '0;
    assign mem.memctrl_radd = addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = start                                ? RUN   :
                    (state == RUN && accept && last)     ? DRAIN :
                    (state == DRAIN && p_vld == '0)      ? DONE  : state;
    end

    always_comb begin
        fwd_hit = 1'b0;
        fwd_dat = '0;
        for (int j = D - 1; j >= 0; j--) begin
            if (h_vld[j] && h_addr[j] == p_addr[D-1]) begin
                fwd_hit = 1'b1;
                fwd_dat = h_dat[j];
            end
        end
        if (mem.memctrl_wren && mem.memctrl_wadd == p_addr[D-1]) begin
            fwd_hit = 1'b1;
            fwd_dat = mem.memctrl_idat;
        end
    end

    assign rdata = !mem.memctrl_ovld ? '0 : fwd_hit ? fwd_dat : mem.memctrl_odat;
    assign wdat  = p_first[D-1] ? p_dat[D-1] : sum;

    for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
        logic signed [BIT_WIDTH:0] s;
        assign s = $signed({rdata[k*BIT_WIDTH+BIT_WIDTH-1], rdata[k*BIT_WIDTH +: BIT_WIDTH]}) +
                   $signed({p_dat[D-1][k*BIT_WIDTH+BIT_WIDTH-1], p_dat[D-1][k*BIT_WIDTH +: BIT_WIDTH]});
`ifdef PSUM_ACC_SAT_EN
        assign lane_sat[k] = s[BIT_WIDTH] != s[BIT_WIDTH-1];
        assign sum[k*BIT_WIDTH +: BIT_WIDTH] = lane_sat[k] ? {s[BIT_WIDTH], {(BIT_WIDTH-1){~s[BIT_WIDTH]}}}
                                                           : s[BIT_WIDTH-1:0];
`else
        assign lane_sat[k] = 1'b0;
        assign sum[k*BIT_WIDTH +: BIT_WIDTH] = s[BIT_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interval <= '0;
            npass    <= '0;
            ngroup   <= '0;
            gstep    <= '0;
            pt_cnt   <= '0;
            pass_cnt <= '0;
            grp_cnt  <= '0;
            base     <= '0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            mem.memctrl_wren <= 1'b0;
            mem.memctrl_wadd <= '0;
            mem.memctrl_idat <= '0;
            p_vld   <= '0;
            p_first <= '0;
            h_vld   <= '0;
            for (int i = 0; i < D; i++) begin
                p_dat[i]  <= '0;
                p_addr[i] <= '0;
                h_dat[i]  <= '0;
                h_addr[i] <= '0;
            end
        end else begin
            if (start) begin
                interval <= i_conf_interval;
                npass    <= i_conf_npass;
                ngroup   <= i_conf_ngroup;
                gstep    <= i_conf_gstep;
                pt_cnt   <= '0;
                pass_cnt <= '0;
                grp_cnt  <= '0;
                base     <= '0;
            end else if (accept) begin
                pt_cnt   <= pt_wrap ? '0 : pt_cnt + REG_WIDTH'(1);
                pass_cnt <= pass_wrap ? '0 : pt_wrap ? pass_cnt + REG_WIDTH'(1) : pass_cnt;
                grp_cnt  <= last ? '0 : pass_wrap ? grp_cnt + REG_WIDTH'(1) : grp_cnt;
                base     <= pass_wrap ? base + gstep : base;
            end
            o_done <= !start && (o_done || (state == DRAIN && state_nxt == DONE));
            // covers both a stray ovld and a missing expected ovld
            o_err  <= !start && (o_err || mem.memctrl_ovld != rd_exp || (rd_exp && |lane_sat));
            mem.memctrl_wren <= p_vld[D-1];
            mem.memctrl_wadd <= p_addr[D-1];
            mem.memctrl_idat <= wdat;
            p_vld[0]   <= accept;
            p_first[0] <= pass_cnt == '0;
            p_dat[0]   <= i_psum_dat;
            p_addr[0]  <= addr;
            h_vld[0]   <= mem.memctrl_wren;
            h_dat[0]   <= mem.memctrl_idat;
            h_addr[0]  <= mem.memctrl_wadd;
            for (int i = 1; i < D; i++) begin
                p_vld[i]   <= p_vld[i-1];
                p_first[i] <= p_first[i-1];
                p_dat[i]   <= p_dat[i-1];
                p_addr[i]  <= p_addr[i-1];
                h_vld[i]   <= h_vld[i-1];
                h_dat[i]   <= h_dat[i-1];
                h_addr[i]  <= h_addr[i-1];
            end
        end
    end
endmodule

// File: tb/tb_psum_accum_engine.sv
// tb_psum_accum_engine: directed scenarios against a read-before-write memory model with MEM_DELAY read latency.
module tb_psum_accum_engine;
    localparam int BW = 8, NK = 4, AW = 32, RW = 32, D = 2, DW = NK * BW;

    logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_psum_vld = 1'b0;
    logic [DW-1:0] i_psum_dat = '0;
    logic [RW-1:0] conf_interval = '0, conf_npass = '0, conf_ngroup = '0;
    logic [AW-1:0] conf_gstep = '0;
    logic o_busy, o_done, o_err;
    int total = 0, bad = 0;

    logic [DW-1:0] ram [256];
    logic [D-1:0]  rq_v;
    logic [DW-1:0] rq_d [D];
    int rd_num = 0, rd_cnt = 0, drop_idx = -1;
    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];

    psum_accum_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    psum_accum_engine #(.BIT_WIDTH(BW), .NUM_KERNEL(NK), .ADDR_WIDTH(AW), .REG_WIDTH(RW), .MEM_DELAY(D)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_psum_dat(i_psum_dat), .i_psum_vld(i_psum_vld),
        .mem(mem_if.master), .i_conf_interval(conf_interval), .i_conf_npass(conf_npass),
        .i_conf_ngroup(conf_ngroup), .i_conf_gstep(conf_gstep), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    assign mem_if.memctrl_ovld = rq_v[D-1];
    assign mem_if.memctrl_odat = rq_d[D-1];

    // reads see memory contents from before a same-edge write
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rq_v <= '0;
        else begin
            rq_v <= {rq_v[0], mem_if.memctrl_rden && rd_num != drop_idx};
            rq_d[1] <= rq_d[0];
            rq_d[0] <= ram[mem_if.memctrl_radd[7:0]];
            if (mem_if.memctrl_rden) begin
                rd_num <= rd_num + 1;
                rd_cnt <= rd_cnt + 1;
            end
            if (mem_if.memctrl_wren) begin
                ram[mem_if.memctrl_wadd[7:0]] <= mem_if.memctrl_idat;
                wa_q.push_back(mem_if.memctrl_wadd);
                wd_q.push_back(mem_if.memctrl_idat);
            end
        end
    end

    task automatic start_job(input int iv, input int np, input int ng, input logic [AW-1:0] gs);
        conf_interval = RW'(iv);
        conf_npass = RW'(np);
        conf_ngroup = RW'(ng);
        conf_gstep = gs;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic feed(input logic [DW-1:0] d);
        i_psum_vld = 1'b1;
        i_psum_dat = d;
        @(negedge clk);
        i_psum_vld = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (o_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (o_done !== 1'b1) begin bad++; $display("FAIL %s done: got %b want 1", nm, o_done); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", o_done); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset err: got %b want 0", o_err); end
        total++; if (mem_if.memctrl_wren !== 1'b0) begin bad++; $display("FAIL reset wren: got %b want 0", mem_if.memctrl_wren); end
        total++; if (mem_if.memctrl_rden !== 1'b0) begin bad++; $display("FAIL reset rden: got %b want 0", mem_if.memctrl_rden); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_pass(input string nm);
        int w0 = wa_q.size(), r0 = rd_cnt;
        logic [DW-1:0] e;
        start_job(4, 1, 1, 0);
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL %s busy: got %b want 1", nm, o_busy); end
        for (int i = 0; i < 4; i++) feed(32'h04030201 + DW'(i) * 32'h10101010);
        wait_done(nm);
        total++; if (wa_q.size() - w0 != 4) begin bad++; $display("FAIL %s wcount: got %0d want 4", nm, wa_q.size() - w0); end
        for (int i = 0; i < 4 && w0 + i < wa_q.size(); i++) begin
            e = 32'h04030201 + DW'(i) * 32'h10101010;
            total++; if (wa_q[w0+i] !== AW'(i)) begin bad++; $display("FAIL %s wadd%0d: got %0h want %0h", nm, i, wa_q[w0+i], i); end
            total++; if (wd_q[w0+i] !== e) begin bad++; $display("FAIL %s wdat%0d: got %h want %h", nm, i, wd_q[w0+i], e); end
        end
        total++; if (rd_cnt != r0) begin bad++; $display("FAIL %s rden: got %0d reads want 0", nm, rd_cnt - r0); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL %s err: got %b want 0", nm, o_err); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL %s idle busy: got %b want 0", nm, o_busy); end
    endtask

    task automatic test_multi_group;
        int w0 = wa_q.size(), r0 = rd_cnt;
        start_job(4, 3, 2, 16);
        repeat (24) feed(32'h01010101);
        wait_done("t2");
        total++; if (wa_q.size() - w0 != 24) begin bad++; $display("FAIL t2 wcount: got %0d want 24", wa_q.size() - w0); end
        total++; if (rd_cnt - r0 != 16) begin bad++; $display("FAIL t2 rcount: got %0d want 16", rd_cnt - r0); end
        for (int i = 0; i < 4; i++) begin
            total++; if (ram[i] !== 32'h03030303) begin bad++; $display("FAIL t2 mem%0d: got %h want 03030303", i, ram[i]); end
            total++; if (ram[16+i] !== 32'h03030303) begin bad++; $display("FAIL t2 mem%0d: got %h want 03030303", 16 + i, ram[16+i]); end
        end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL t2 err: got %b want 0", o_err); end
    endtask

    task automatic test_back_to_back;
        int w0 = wa_q.size();
        logic [DW-1:0] e;
        start_job(1, 5, 1, 0);
        repeat (5) feed(32'h02020202);
        wait_done("t3");
        total++; if (wa_q.size() - w0 != 5) begin bad++; $display("FAIL t3 wcount: got %0d want 5", wa_q.size() - w0); end
        for (int i = 0; i < 5 && w0 + i < wa_q.size(); i++) begin
            e = {4{8'(2 * (i + 1))}};
            total++; if (wa_q[w0+i] !== '0) begin bad++; $display("FAIL t3 wadd%0d: got %0h want 0", i, wa_q[w0+i]); end
            total++; if (wd_q[w0+i] !== e) begin bad++; $display("FAIL t3 wdat%0d: got %h want %h", i, wd_q[w0+i], e); end
        end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL t3 err: got %b want 0", o_err); end
    endtask

    task automatic test_forward_window;
        logic [DW-1:0] e;
        for (int iv = 2; iv <= 3; iv++) begin
            start_job(iv, 3, 1, 0);
            for (int p = 0; p < 3; p++)
                for (int i = 0; i < iv; i++) feed({4{8'(i + 1)}});
            wait_done("fwd");
            for (int i = 0; i < iv; i++) begin
                e = {4{8'(3 * (i + 1))}};
                total++; if (ram[i] !== e) begin bad++; $display("FAIL fwd iv%0d mem%0d: got %h want %h", iv, i, ram[i], e); end
            end
        end
    endtask

    task automatic test_ovld_drop;
        int w0 = wa_q.size();
        logic [DW-1:0] e;
        drop_idx = rd_num + 1;
        start_job(4, 2, 1, 0);
        repeat (4) feed(32'h05050505);
        repeat (4) feed(32'h01010101);
        wait_done("t4");
        total++; if (wa_q.size() - w0 != 8) begin bad++; $display("FAIL t4 wcount: got %0d want 8", wa_q.size() - w0); end
        for (int i = 4; i < 8 && w0 + i < wa_q.size(); i++) begin
            e = (i == 5) ? 32'h01010101 : 32'h06060606;
            total++; if (wd_q[w0+i] !== e) begin bad++; $display("FAIL t4 wdat%0d: got %h want %h", i, wd_q[w0+i], e); end
        end
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL t4 err set: got %b want 1", o_err); end
        drop_idx = -1;
        start_job(4, 1, 1, 0);
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL t4 err clear: got %b want 0", o_err); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL t4 done clear: got %b want 0", o_done); end
        repeat (4) feed(32'h0);
        wait_done("t4b");
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL t4 err after: got %b want 0", o_err); end
    endtask

    task automatic test_lane_wrap;
        int w0 = wa_q.size();
`ifdef PSUM_ACC_SAT_EN
        logic [DW-1:0] e = 32'h0000807F;
        logic e_err = 1'b1;
`else
        logic [DW-1:0] e = 32'h00007F80;
        logic e_err = 1'b0;
`endif
        start_job(4, 2, 1, 0);
        feed(32'h0000807F);
        repeat (3) feed(32'h0);
        feed(32'h0000FF01);
        repeat (3) feed(32'h0);
        wait_done("t5");
        total++; if (wd_q[w0+4] !== e) begin bad++; $display("FAIL t5 wdat: got %h want %h", wd_q[w0+4], e); end
        total++; if (wd_q[w0+5] !== '0) begin bad++; $display("FAIL t5 zero lane: got %h want 0", wd_q[w0+5]); end
        total++; if (o_err !== e_err) begin bad++; $display("FAIL t5 err: got %b want %b", o_err, e_err); end
    endtask

    task automatic test_reset_abort;
        int w0;
        start_job(2, 2, 1, 0);
        repeat (3) feed(32'h11111111);
        total++; if (mem_if.memctrl_wren !== 1'b1) begin bad++; $display("FAIL t6 inflight wren: got %b want 1", mem_if.memctrl_wren); end
        #2 rst_n = 1'b0;
        #1;
        w0 = wa_q.size();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL t6 busy: got %b want 0", o_busy); end
        total++; if (mem_if.memctrl_wren !== 1'b0) begin bad++; $display("FAIL t6 wren: got %b want 0", mem_if.memctrl_wren); end
        total++; if (o_done !== 1'b0 || o_err !== 1'b0) begin bad++; $display("FAIL t6 status: got %b%b want 00", o_done, o_err); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (wa_q.size() != w0) begin bad++; $display("FAIL t6 stray writes: got %0d want 0", wa_q.size() - w0); end
        test_single_pass("t6");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
        test_reset();
        test_single_pass("t1");
        test_multi_group();
        test_back_to_back();
        test_forward_window();
        test_ovld_drop();
        test_lane_wrap();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
